// File: rtl/tl_hdr_parse.sv
// Transaction-layer header parser: accepts one 128-bit header, decodes it
// into request/completion fields, and reports malformed or unsupported types.
`timescale 1ns/1ps
module tl_hdr_parse #(
    parameter int TAG_W             = 8,
    parameter int MAX_PAYLOAD_BYTES = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [127:0]       hdr_i,
    input  logic               hdr_valid_i,
    output logic               hdr_ready_o,
    output logic [2:0]         dec_kind_o,
    output logic [63:0]        dec_addr_o,
    output logic [10:0]        dec_len_o,
    output logic [15:0]        dec_req_id_o,
    output logic [TAG_W-1:0]   dec_tag_o,
    output logic [3:0]         dec_first_be_o,
    output logic [3:0]         dec_last_be_o,
    output logic [2:0]         dec_cpl_status_o,
    output logic [11:0]        dec_byte_cnt_o,
    output logic               dec_has_data_o,
    output logic               dec_posted_o,
    output logic               dec_valid_o,
    input  logic               dec_ready_i,
    output logic               tag_release_o,
    output logic [TAG_W-1:0]   tag_release_id_o,
    output logic               malformed_o,
    output logic               unsupported_o
);
    typedef enum logic [1:0] {IDLE, CHECK, OUT, ERR} state_t;

    localparam logic [2:0]  K_MRD   = 3'd0;
    localparam logic [2:0]  K_MWR   = 3'd1;
    localparam logic [2:0]  K_CFGRD = 3'd2;
    localparam logic [2:0]  K_CFGWR = 3'd3;
    localparam logic [2:0]  K_CPL   = 3'd4;
    localparam logic [2:0]  K_CPLD  = 3'd5;
    localparam logic [31:0] MAX_B   = MAX_PAYLOAD_BYTES;

    state_t             state_q, state_d;
    logic               ready_en_q;
    logic [127:0]       hdr_q, hdr_d;
    logic [2:0]         kind_q, kind_d;
    logic [63:0]        addr_q, addr_d;
    logic [10:0]        len_q, len_d;
    logic [15:0]        req_id_q, req_id_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [3:0]         fbe_q, fbe_d, lbe_q, lbe_d;
    logic [2:0]         status_q, status_d;
    logic [11:0]        bc_q, bc_d;
    logic               has_data_q, has_data_d, posted_q, posted_d;
    logic               mal_q, mal_d, unsup_q, unsup_d, rel_q, rel_d;

    // Decoded view of the registered header, consumed only in CHECK
    logic               f_sup, f_four_dw, f_mal, f_rel;
    logic               f_is_req, f_is_cfg, f_is_cpl;
    logic [2:0]         f_kind;
    logic [10:0]        f_len;
    logic [12:0]        f_len_bytes, f_bc_bytes;
    logic [63:0]        f_addr;
    logic [15:0]        f_req_id;
    logic [TAG_W-1:0]   f_tag;
    logic [3:0]         f_fbe, f_lbe;
    logic [2:0]         f_status;
    logic [11:0]        f_bc;
    logic               f_has_data, f_posted;
    logic               unused_hdr_bits;

    assign unused_hdr_bits = ^{hdr_q[119:111], hdr_q[109:106], hdr_q[1:0]};

    always_comb begin
        f_sup     = 1'b1;
        f_four_dw = 1'b0;
        f_kind    = K_MRD;
        case (hdr_q[127:120])
            8'h00:   f_kind = K_MRD;
            8'h20:   begin f_kind = K_MRD; f_four_dw = 1'b1; end
            8'h40:   f_kind = K_MWR;
            8'h60:   begin f_kind = K_MWR; f_four_dw = 1'b1; end
            8'h04:   f_kind = K_CFGRD;
            8'h44:   f_kind = K_CFGWR;
            8'h0A:   f_kind = K_CPL;
            8'h4A:   f_kind = K_CPLD;
            default: f_sup = 1'b0;
        endcase

        f_is_cfg = (f_kind == K_CFGRD) || (f_kind == K_CFGWR);
        f_is_cpl = (f_kind == K_CPL) || (f_kind == K_CPLD);
        f_is_req = !f_is_cpl;

        f_len       = (hdr_q[105:96] == 10'd0) ? 11'd1024 : {1'b0, hdr_q[105:96]};
        f_len_bytes = {f_len, 2'b00};

        f_addr = 64'h0;
        if (f_is_cpl)
            f_addr = {57'h0, hdr_q[38:32]};
        else if (f_is_cfg)
            f_addr = {32'h0, hdr_q[63:48], 4'h0, hdr_q[43:34], 2'b00};
        else if (f_four_dw)
            f_addr = {hdr_q[63:2], 2'b00};
        else
            f_addr = {32'h0, hdr_q[63:34], 2'b00};

        f_req_id = f_is_req ? hdr_q[95:80] : hdr_q[63:48];
        f_tag    = f_is_req ? TAG_W'(hdr_q[79:72]) : TAG_W'(hdr_q[47:40]);
        f_fbe    = f_is_req ? hdr_q[67:64] : 4'h0;
        f_lbe    = f_is_req ? hdr_q[71:68] : 4'h0;
        f_status = f_is_cpl ? hdr_q[79:77] : 3'h0;
        f_bc     = f_is_cpl ? hdr_q[75:64] : 12'h0;
        // A zero byte count stands for a full 4 KB remaining
        f_bc_bytes = (hdr_q[75:64] == 12'd0) ? 13'd4096 : {1'b0, hdr_q[75:64]};

        f_has_data = (f_kind == K_MWR) || (f_kind == K_CFGWR) || (f_kind == K_CPLD);
        f_posted   = (f_kind == K_MWR);

        f_mal = hdr_q[110]
              || (((f_kind == K_MWR) || (f_kind == K_CPLD)) && ({19'h0, f_len_bytes} > MAX_B))
              || (f_is_cfg && (f_len != 11'd1))
              || ((f_kind == K_CPL) && (f_status == 3'd0));
        f_rel = f_is_cpl && ((f_status != 3'd0) || (f_bc_bytes <= f_len_bytes));
    end

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        kind_d     = kind_q;
        addr_d     = addr_q;
        len_d      = len_q;
        req_id_d   = req_id_q;
        tag_d      = tag_q;
        fbe_d      = fbe_q;
        lbe_d      = lbe_q;
        status_d   = status_q;
        bc_d       = bc_q;
        has_data_d = has_data_q;
        posted_d   = posted_q;
        mal_d      = mal_q;
        unsup_d    = unsup_q;
        rel_d      = rel_q;
        case (state_q)
            IDLE: begin
                if (hdr_valid_i && ready_en_q) begin
                    hdr_d   = hdr_i;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                unsup_d = !f_sup;
                mal_d   = f_sup && f_mal;
                if (!f_sup || f_mal) begin
                    // Dropped headers leave nothing behind on the decode outputs
                    kind_d = 3'd0; addr_d = 64'h0; len_d = 11'd0; req_id_d = 16'h0;
                    tag_d = '0; fbe_d = 4'h0; lbe_d = 4'h0; status_d = 3'd0;
                    bc_d = 12'h0; has_data_d = 1'b0; posted_d = 1'b0; rel_d = 1'b0;
                    state_d = ERR;
                end else begin
                    kind_d = f_kind; addr_d = f_addr; len_d = f_len; req_id_d = f_req_id;
                    tag_d = f_tag; fbe_d = f_fbe; lbe_d = f_lbe; status_d = f_status;
                    bc_d = f_bc; has_data_d = f_has_data; posted_d = f_posted; rel_d = f_rel;
                    state_d = OUT;
                end
            end
            OUT:     if (dec_ready_i) state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_en_q <= 1'b0;
            hdr_q      <= '0;
            kind_q     <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            req_id_q   <= '0;
            tag_q      <= '0;
            fbe_q      <= '0;
            lbe_q      <= '0;
            status_q   <= '0;
            bc_q       <= '0;
            has_data_q <= 1'b0;
            posted_q   <= 1'b0;
            mal_q      <= 1'b0;
            unsup_q    <= 1'b0;
            rel_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            hdr_q      <= hdr_d;
            kind_q     <= kind_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            req_id_q   <= req_id_d;
            tag_q      <= tag_d;
            fbe_q      <= fbe_d;
            lbe_q      <= lbe_d;
            status_q   <= status_d;
            bc_q       <= bc_d;
            has_data_q <= has_data_d;
            posted_q   <= posted_d;
            mal_q      <= mal_d;
            unsup_q    <= unsup_d;
            rel_q      <= rel_d;
        end
    end

    assign hdr_ready_o      = ready_en_q && (state_q == IDLE);
    assign dec_valid_o      = (state_q == OUT);
    assign dec_kind_o       = kind_q;
    assign dec_addr_o       = addr_q;
    assign dec_len_o        = len_q;
    assign dec_req_id_o     = req_id_q;
    assign dec_tag_o        = tag_q;
    assign dec_first_be_o   = fbe_q;
    assign dec_last_be_o    = lbe_q;
    assign dec_cpl_status_o = status_q;
    assign dec_byte_cnt_o   = bc_q;
    assign dec_has_data_o   = has_data_q;
    assign dec_posted_o     = posted_q;
    assign tag_release_o    = (state_q == OUT) && dec_ready_i && rel_q;
    assign tag_release_id_o = tag_q;
    assign unsupported_o    = (state_q == ERR) && unsup_q;
    assign malformed_o      = (state_q == ERR) && mal_q;
endmodule

// File: tb/tb_tl_hdr_parse.sv
// Directed bench for tl_hdr_parse: a table of headers with hand-decoded
// expectations, plus back-pressure and reset-during-output sequences.
`timescale 1ns/1ps
module tb_tl_hdr_parse;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] hdr_i;
    logic         hdr_valid_i;
    logic         hdr_ready_o;
    logic [2:0]   dec_kind_o;
    logic [63:0]  dec_addr_o;
    logic [10:0]  dec_len_o;
    logic [15:0]  dec_req_id_o;
    logic [7:0]   dec_tag_o;
    logic [3:0]   dec_first_be_o, dec_last_be_o;
    logic [2:0]   dec_cpl_status_o;
    logic [11:0]  dec_byte_cnt_o;
    logic         dec_has_data_o, dec_posted_o, dec_valid_o, dec_ready_i;
    logic         tag_release_o;
    logic [7:0]   tag_release_id_o;
    logic         malformed_o, unsupported_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tl_hdr_parse #(.TAG_W(8), .MAX_PAYLOAD_BYTES(256)) dut (
        .clk(clk), .rst_n(rst_n), .hdr_i(hdr_i), .hdr_valid_i(hdr_valid_i),
        .hdr_ready_o(hdr_ready_o), .dec_kind_o(dec_kind_o), .dec_addr_o(dec_addr_o),
        .dec_len_o(dec_len_o), .dec_req_id_o(dec_req_id_o), .dec_tag_o(dec_tag_o),
        .dec_first_be_o(dec_first_be_o), .dec_last_be_o(dec_last_be_o),
        .dec_cpl_status_o(dec_cpl_status_o), .dec_byte_cnt_o(dec_byte_cnt_o),
        .dec_has_data_o(dec_has_data_o), .dec_posted_o(dec_posted_o),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .tag_release_o(tag_release_o), .tag_release_id_o(tag_release_id_o),
        .malformed_o(malformed_o), .unsupported_o(unsupported_o)
    );

    typedef struct {
        logic [127:0] hdr;
        logic [1:0]   err;   // 0 ok, 1 malformed, 2 unsupported
        logic [2:0]   kind;
        logic [10:0]  len;
        logic [63:0]  addr;
        logic [15:0]  req;
        logic [7:0]   tag;
        logic [3:0]   fbe;
        logic [3:0]   lbe;
        logic [2:0]   st;
        logic [11:0]  bc;
        logic         hd;
        logic         po;
        logic         rel;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the CHECK cycle (N+1) of the sent header
    task automatic send(input logic [127:0] h);
        int n = 0;
        while (!hdr_ready_o && n < 20) begin
            tick();
            n++;
        end
        chk("hdr_ready_wait", hdr_ready_o, 1);
        hdr_i       = h;
        hdr_valid_i = 1'b1;
        tick();
        hdr_valid_i = 1'b0;
        hdr_i       = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        send(v.hdr);
        chk("check_cycle_valid", dec_valid_o, 0);
        chk("check_cycle_ready", hdr_ready_o, 0);
        tick();
        if (v.err == 2'd0) begin
            chk("valid_n2", dec_valid_o, 1);
            chk("kind", dec_kind_o, v.kind);
            chk("len", dec_len_o, v.len);
            chk("addr", dec_addr_o, v.addr);
            chk("req_id", dec_req_id_o, v.req);
            chk("tag", dec_tag_o, v.tag);
            chk("first_be", dec_first_be_o, v.fbe);
            chk("last_be", dec_last_be_o, v.lbe);
            chk("cpl_status", dec_cpl_status_o, v.st);
            chk("byte_cnt", dec_byte_cnt_o, v.bc);
            chk("has_data", dec_has_data_o, v.hd);
            chk("posted", dec_posted_o, v.po);
            chk("tag_release", tag_release_o, v.rel);
            if (v.rel) chk("tag_release_id", tag_release_id_o, v.tag);
            chk("no_malformed", malformed_o, 0);
            chk("no_unsupported", unsupported_o, 0);
        end else begin
            chk("err_no_valid", dec_valid_o, 0);
            chk("malformed", malformed_o, v.err == 2'd1);
            chk("unsupported", unsupported_o, v.err == 2'd2);
            chk("err_no_release", tag_release_o, 0);
        end
        tick();
        chk("ready_after", hdr_ready_o, 1);
        chk("pulse_gone_mal", malformed_o, 0);
        chk("pulse_gone_unsup", unsupported_o, 0);
        chk("valid_gone", dec_valid_o, 0);
        $display("vec %0d hdr=%032h err=%0d kind=%0d len=%0d checks=%0d errors=%0d",
                 idx, v.hdr, v.err, v.kind, v.len, checks, errors);
    endtask

    initial begin
        //          hdr                                                       err kind len    addr                    req      tag    fbe  lbe  st   bc      hd po rel
        vecs[0]  = '{{32'h4000_0004, 32'h0100_00FF, 32'h1000_0000, 32'h0}, 0, 1, 11'd4,   64'h0000_0000_1000_0000, 16'h0100, 8'h00, 4'hF, 4'hF, 3'd0, 12'd0, 1, 1, 0};
        vecs[1]  = '{{32'h2000_0000, 32'h0ABC_2A3C, 32'h0000_0001, 32'h2345_6788}, 0, 0, 11'd1024, 64'h0000_0001_2345_6788, 16'h0ABC, 8'h2A, 4'hC, 4'h3, 3'd0, 12'd0, 0, 0, 0};
        vecs[2]  = '{{32'h0400_0001, 32'h0010_5501, 32'h0108_0ABC, 32'h0}, 0, 2, 11'd1,   64'h0000_0000_0108_0ABC, 16'h0010, 8'h55, 4'h1, 4'h0, 3'd0, 12'd0, 0, 0, 0};
        vecs[3]  = '{{32'h4400_0001, 32'h0020_660F, 32'hFFFF_F3FC, 32'h0}, 0, 3, 11'd1,   64'h0000_0000_FFFF_03FC, 16'h0020, 8'h66, 4'hF, 4'h0, 3'd0, 12'd0, 1, 0, 0};
        vecs[4]  = '{{32'h0A00_0000, 32'hBEEF_2004, 32'h0100_7700, 32'h0}, 0, 4, 11'd1024, 64'h0,                  16'h0100, 8'h77, 4'h0, 4'h0, 3'd1, 12'd4, 0, 0, 1};
        vecs[5]  = '{{32'h4A00_0001, 32'h0000_0004, 32'h0200_3344, 32'h0}, 0, 5, 11'd1,   64'h44,                  16'h0200, 8'h33, 4'h0, 4'h0, 3'd0, 12'd4, 1, 0, 1};
        vecs[6]  = '{{32'h4A00_0001, 32'h0000_0008, 32'h0300_4400, 32'h0}, 0, 5, 11'd1,   64'h0,                   16'h0300, 8'h44, 4'h0, 4'h0, 3'd0, 12'd8, 1, 0, 0};
        vecs[7]  = '{{32'h4A00_0040, 32'h0000_0000, 32'h0400_5500, 32'h0}, 0, 5, 11'd64,  64'h0,                   16'h0400, 8'h55, 4'h0, 4'h0, 3'd0, 12'd0, 1, 0, 0};
        vecs[8]  = '{{32'h6000_0080, 32'h0,         32'h0,         32'h0}, 1, 0, 11'd0,   64'h0, 16'h0, 8'h0, 4'h0, 4'h0, 3'd0, 12'd0, 0, 0, 0};
        vecs[9]  = '{{32'h3000_0001, 32'h0,         32'h0,         32'h0}, 2, 0, 11'd0,   64'h0, 16'h0, 8'h0, 4'h0, 4'h0, 3'd0, 12'd0, 0, 0, 0};
        vecs[10] = '{{32'h0400_0002, 32'h0,         32'h0,         32'h0}, 1, 0, 11'd0,   64'h0, 16'h0, 8'h0, 4'h0, 4'h0, 3'd0, 12'd0, 0, 0, 0};
        vecs[11] = '{{32'h0A00_0000, 32'h0,         32'h0,         32'h0}, 1, 0, 11'd0,   64'h0, 16'h0, 8'h0, 4'h0, 4'h0, 3'd0, 12'd0, 0, 0, 0};
        vecs[12] = '{{32'h0000_4001, 32'h0,         32'h0,         32'h0}, 1, 0, 11'd0,   64'h0, 16'h0, 8'h0, 4'h0, 4'h0, 3'd0, 12'd0, 0, 0, 0};
        vecs[13] = '{{32'h3000_4001, 32'h0,         32'h0,         32'h0}, 2, 0, 11'd0,   64'h0, 16'h0, 8'h0, 4'h0, 4'h0, 3'd0, 12'd0, 0, 0, 0};
        vecs[14] = '{{32'h4000_0040, 32'h0,         32'h0000_0004, 32'h0}, 0, 1, 11'd64,  64'h4,                   16'h0, 8'h0, 4'h0, 4'h0, 3'd0, 12'd0, 1, 1, 0};
        vecs[15] = '{{32'h4A00_0041, 32'h0,         32'h0,         32'h0}, 1, 0, 11'd0,   64'h0, 16'h0, 8'h0, 4'h0, 4'h0, 3'd0, 12'd0, 0, 0, 0};

        rst_n       = 1'b0;
        hdr_i       = '0;
        hdr_valid_i = 1'b0;
        dec_ready_i = 1'b1;
        #12;
        chk("rst_ready", hdr_ready_o, 0);
        chk("rst_valid", dec_valid_o, 0);
        chk("rst_release", tag_release_o, 0);
        chk("rst_malformed", malformed_o, 0);
        chk("rst_unsupported", unsupported_o, 0);
        chk("rst_addr", dec_addr_o, 0);
        chk("rst_len", dec_len_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", hdr_ready_o, 1);
        $display("reset released, hdr_ready_o=%0b", hdr_ready_o);

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Back-pressure on a final completion: fields hold, release only on handshake
        dec_ready_i = 1'b0;
        send({32'h4A00_0002, 32'h0000_0008, 32'h0000_1500, 32'h0});
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", dec_valid_o, 1);
            chk("stall_kind", dec_kind_o, 5);
            chk("stall_len", dec_len_o, 2);
            chk("stall_tag", dec_tag_o, 8'h15);
            chk("stall_bc", dec_byte_cnt_o, 8);
            chk("stall_no_release", tag_release_o, 0);
            chk("stall_not_ready", hdr_ready_o, 0);
            tick();
        end
        dec_ready_i = 1'b1;
        #1;
        chk("stall_release", tag_release_o, 1);
        chk("stall_release_id", tag_release_id_o, 8'h15);
        tick();
        chk("stall_done_valid", dec_valid_o, 0);
        chk("stall_done_release", tag_release_o, 0);
        $display("stall sequence done, checks=%0d errors=%0d", checks, errors);

        // Reset while a final completion is waiting in OUT
        dec_ready_i = 1'b0;
        send(vecs[5].hdr);
        tick();
        chk("pre_rst_valid", dec_valid_o, 1);
        rst_n = 1'b0;
        #1;
        dec_ready_i = 1'b1;
        #1;
        chk("midrst_valid", dec_valid_o, 0);
        chk("midrst_release", tag_release_o, 0);
        chk("midrst_ready", hdr_ready_o, 0);
        chk("midrst_kind", dec_kind_o, 0);
        chk("midrst_tag", dec_tag_o, 0);
        chk("midrst_malformed", malformed_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", hdr_ready_o, 1);
        chk("post_rst_release", tag_release_o, 0);
        chk("post_rst_unsup", unsupported_o, 0);
        $display("mid-OUT reset done, checks=%0d errors=%0d", checks, errors);
        run_vec(0, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
